// File: rtl/alu_div_sched.sv
// alu_div_sched: round-robin arbiter sharing one sequential ALU_DIV divider
// between NUM_REQ requesters. One job is in flight at a time. Every divider
// job is preceded by a one-cycle FLUSH with an inverted dividend so the
// divider always sees an operand change and restarts. Divide-by-zero is
// answered directly. A watchdog turns a hung divider into an error response.
//
// Optional feature: define ALU_DIV_SCHED_CACHE_EN to keep the last completed
// non-error job and answer an identical job without touching the divider.
module alu_div_sched #(
  parameter int NUM_REQ  = 2,
  parameter int ID_W     = 1,
  parameter int MIN_WAIT = 2,
  parameter int MAX_WAIT = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_dividend,
  input  logic [32*NUM_REQ-1:0]   req_divisor,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_quotient,
  output logic [31:0]             rsp_remainder,
  output logic                    rsp_err,
  output logic [31:0]             div_dividend,
  output logic [31:0]             div_divisor,
  input  logic                    div_done,
  input  logic [31:0]             div_quotient,
  input  logic [31:0]             div_remainder
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] wait_cnt;

  logic [31:0]      cap_dividend;
  logic [31:0]      cap_divisor;

  logic             hi_any;
  logic             lo_any;
  logic [ID_W-1:0]  hi_idx;
  logic [ID_W-1:0]  lo_idx;
  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic [31:0]      sel_dividend;
  logic [31:0]      sel_divisor;

  logic             accept;
  logic             done_take;
  logic             wd_expire;

  logic             cache_hit;
  logic [31:0]      cache_q;
  logic [31:0]      cache_r;

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest overall
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_any = 1'b1;
        lo_idx = ID_W'(i);
        if (ID_W'(i) >= rr_ptr) begin
          hi_any = 1'b1;
          hi_idx = ID_W'(i);
        end
      end
    end
    grant_any = hi_any | lo_any;
    grant_idx = hi_any ? hi_idx : lo_idx;
  end

  // Operand mux for the winning requester
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_dividend = req_dividend[32*i +: 32];
        sel_divisor  = req_divisor[32*i +: 32];
      end
    end
  end

  // One-hot grant, only while idle and never while reset is asserted
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == S_IDLE) && grant_any) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_idx == ID_W'(i)) req_ready[i] = 1'b1;
      end
    end
  end

  assign accept    = (state == S_IDLE) && grant_any;
  assign done_take = (state == S_WAIT) && (wait_cnt >= MIN_CNT) && div_done;
  assign wd_expire = (state == S_WAIT) && !done_take && (wait_cnt == LAST_CNT);
  assign rsp_valid = (state == S_RESP);

`ifdef ALU_DIV_SCHED_CACHE_EN
  logic        cache_vld;
  logic [31:0] cache_dd;
  logic [31:0] cache_dv;

  assign cache_hit = cache_vld && (sel_dividend == cache_dd) && (sel_divisor == cache_dv);

  // Remember the most recent divider result that completed without timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld <= 1'b0;
      cache_dd  <= '0;
      cache_dv  <= '0;
      cache_q   <= '0;
      cache_r   <= '0;
    end else if (done_take) begin
      cache_vld <= 1'b1;
      cache_dd  <= cap_dividend;
      cache_dv  <= cap_divisor;
      cache_q   <= div_quotient;
      cache_r   <= div_remainder;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_q   = '0;
  assign cache_r   = '0;
`endif

  // Control: FSM state, round-robin pointer and WAIT watchdog counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
            if ((sel_divisor == 32'd0) || cache_hit) state <= S_RESP;
            else                                     state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (done_take || wd_expire) state <= S_RESP;
          else                        wait_cnt <= wait_cnt + 1'b1;
        end
        default: begin
          if (rsp_ready) state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: captured job, divider operand drive and response fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_dividend  <= '0;
      cap_divisor   <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_dividend <= sel_dividend;
            cap_divisor  <= sel_divisor;
            rsp_id       <= grant_idx;
            rsp_err      <= 1'b0;
            if (sel_divisor == 32'd0) begin
              rsp_quotient  <= 32'hFFFF_FFFF;
              rsp_remainder <= sel_dividend;
            end else if (cache_hit) begin
              rsp_quotient  <= cache_q;
              rsp_remainder <= cache_r;
            end else begin
              // Inverted dividend forces the divider to see new operands
              div_dividend <= ~sel_dividend;
              div_divisor  <= sel_divisor;
            end
          end
        end
        S_FLUSH: begin
          div_dividend <= cap_dividend;
          div_divisor  <= cap_divisor;
        end
        S_WAIT: begin
          if (done_take) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
            rsp_err       <= 1'b0;
          end else if (wd_expire) begin
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_err       <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sched.sv
// Bench for alu_div_sched with a behavioural ALU_DIV model that restarts on
// any operand change and raises done after a configurable number of cycles.
// Build with ALU_DIV_SCHED_CACHE_EN defined to exercise the result cache.
module tb_alu_div_sched;

  localparam int NUM_REQ  = 2;
  localparam int ID_W     = 1;
  localparam int MIN_WAIT = 2;
  localparam int MAX_WAIT = 40;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_dividend = '0;
  logic [32*NUM_REQ-1:0] req_divisor = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_quotient;
  logic [31:0]           rsp_remainder;
  logic                  rsp_err;
  logic [31:0]           div_dividend;
  logic [31:0]           div_divisor;
  logic                  div_done;
  logic [31:0]           div_quotient;
  logic [31:0]           div_remainder;

  alu_div_sched #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .MIN_WAIT(MIN_WAIT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model
  int          model_lat = 8;
  int          mcnt = 0;
  logic [31:0] prev_dd = '0;
  logic [31:0] prev_dv = '0;
  logic        force_hi = 1'b0;
  logic        force_lo = 1'b0;

  always @(posedge clk) begin
    if ((div_dividend != prev_dd) || (div_divisor != prev_dv)) mcnt <= model_lat;
    else if (mcnt != 0) mcnt <= mcnt - 1;
    prev_dd <= div_dividend;
    prev_dv <= div_divisor;
  end

  assign div_done      = force_lo ? 1'b0 : (force_hi ? 1'b1 : (mcnt == 0));
  assign div_quotient  = force_hi ? 32'hDEAD_BEEF :
                         ((div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor);
  assign div_remainder = force_hi ? 32'hBAD0_BAD0 :
                         ((div_divisor == 0) ? div_dividend : div_dividend % div_divisor);

  int          checks = 0;
  int          errors = 0;
  int          acc_cyc = 0;
  int          lat;
  bit          ok;
  logic [31:0] last_dd = '0;
  logic [31:0] last_dv = '0;

  typedef struct {
    int          id;
    logic [31:0] dd;
    logic [31:0] dv;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s actual=%0d required>=%0d", name, act, min);
    end
  endtask

  // Present a job on requester id, wait for its grant, return at mid-cycle A+1
  task automatic issue(input int id, input logic [31:0] dd, input logic [31:0] dv);
    bit got;
    got = 1'b0;
    req_dividend[32*id +: 32] = dd;
    req_divisor[32*id +: 32]  = dv;
    req_valid[id] = 1'b1;
    #1;
    for (int t = 0; t < 200 && !got; t++) begin
      if (req_ready[id]) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout id=%0d actual req_ready=%b required grant", id, req_ready);
    end
    acc_cyc = cyc;
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, output int l, output bit seen);
    seen = 1'b0;
    l = -1;
    for (int t = 0; t < bound && !seen; t++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        l = cyc - acc_cyc;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rsp_timeout actual rsp_valid=0 required rsp_valid=1 within %0d cycles", bound);
    end
  endtask

  task automatic chk_rsp(input string name, input logic [31:0] id, input logic [31:0] q,
                         input logic [31:0] r, input logic err);
    chk({name, "_id"}, rsp_id, id);
    chk({name, "_q"}, rsp_quotient, q);
    chk({name, "_r"}, rsp_remainder, r);
    chk({name, "_err"}, rsp_err, err);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_req_ready"}, req_ready, 0);
    chk({name, "_rsp_valid"}, rsp_valid, 0);
    chk({name, "_rsp_id"}, rsp_id, 0);
    chk({name, "_rsp_q"}, rsp_quotient, 0);
    chk({name, "_rsp_r"}, rsp_remainder, 0);
    chk({name, "_rsp_err"}, rsp_err, 0);
    chk({name, "_div_dd"}, div_dividend, 0);
    chk({name, "_div_dv"}, div_divisor, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0] = '{0, 32'd100,        32'd7,        32'd14,         32'd2};
    vecs[1] = '{1, 32'd5,          32'd0,        32'hFFFF_FFFF,  32'd5};
    vecs[2] = '{1, 32'hFFFF_FFFF,  32'd16,       32'h0FFF_FFFF,  32'd15};
    vecs[3] = '{0, 32'd0,          32'd3,        32'd0,          32'd0};
    vecs[4] = '{1, 32'd7,          32'd100,      32'd0,          32'd7};
    vecs[5] = '{0, 32'h8000_0000,  32'd1,        32'h8000_0000,  32'd0};
    vecs[6] = '{0, 32'd12345678,   32'd12345678, 32'd1,          32'd0};
    vecs[7] = '{1, 32'd0,          32'd0,        32'hFFFF_FFFF,  32'd0};

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Two requesters valid continuously: grants alternate starting at 0
    req_dividend = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    req_divisor  = {32'd16, 32'd16};
    req_valid    = 2'b11;
    #1;
    for (int j = 0; j < 4; j++) begin
      bit got;
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
        if (|req_ready) got = 1'b1;
        else @(negedge clk);
      end
      chk("rr_grant", req_ready, (j % 2 == 0) ? 32'd1 : 32'd2);
      acc_cyc = cyc;
      @(negedge clk);
      if (j == 3) req_valid = '0;
      wait_rsp(100, lat, ok);
      if (ok) chk_rsp("rr_rsp", j % 2, 32'h0FFF_FFFF, 32'd15, 1'b0);
      @(negedge clk);
    end
    last_dd = 32'hFFFF_FFFF;
    last_dv = 32'd16;

    // Table-driven jobs
    for (int v = 0; v < 8; v++) begin
      issue(vecs[v].id, vecs[v].dd, vecs[v].dv);
      if (vecs[v].dv != 0) begin
        chk("flush_dd", div_dividend, ~vecs[v].dd);
        chk("flush_dv", div_divisor, vecs[v].dv);
      end
      wait_rsp(100, lat, ok);
      if (ok) begin
        chk_rsp("vec", vecs[v].id, vecs[v].q, vecs[v].r, 1'b0);
        if (vecs[v].dv == 0) begin
          chk("dz_latency", lat, 1);
          chk("dz_div_dd_hold", div_dividend, last_dd);
          chk("dz_div_dv_hold", div_divisor, last_dv);
        end else begin
          chk_ge("div_latency", lat, MIN_WAIT + 3);
          chk("wait_div_dd", div_dividend, vecs[v].dd);
        end
      end
      if (vecs[v].dv != 0) begin
        last_dd = vecs[v].dd;
        last_dv = vecs[v].dv;
      end
      @(negedge clk);
    end

    // Earliest response: divider done immediately
    model_lat = 0;
    issue(0, 32'd100, 32'd7);
    chk("early_flush_dd", div_dividend, 32'hFFFF_FF9B);
    @(negedge clk);
    chk("early_wait_dd", div_dividend, 32'd100);
    wait_rsp(100, lat, ok);
    if (ok) begin
      chk("early_latency", lat, MIN_WAIT + 3);
      chk_rsp("early", 0, 32'd14, 32'd2, 1'b0);
    end
    @(negedge clk);
    model_lat = 8;

    // Stale done high during the first MIN_WAIT WAIT cycles is ignored
    issue(1, 32'd1000, 32'd10);
    force_hi = 1'b1;
    for (int i = 0; i < MIN_WAIT + 1; i++) begin
      @(negedge clk);
      chk("stale_no_rsp", rsp_valid, 0);
    end
    force_hi = 1'b0;
    wait_rsp(100, lat, ok);
    if (ok) chk_rsp("stale", 1, 32'd100, 32'd0, 1'b0);
    @(negedge clk);

    // Divider hung: watchdog error response
    force_lo = 1'b1;
    issue(0, 32'd77, 32'd3);
    wait_rsp(100, lat, ok);
    if (ok) begin
      chk("wd_latency", lat, MAX_WAIT + 2);
      chk_rsp("wd", 0, 32'd0, 32'd0, 1'b1);
    end
    @(negedge clk);
    force_lo = 1'b0;

    // Response back-pressure: fields stable, no grant while stalled
    rsp_ready = 1'b0;
    issue(0, 32'd9, 32'd0);
    req_dividend[63:32] = 32'd50;
    req_divisor[63:32]  = 32'd5;
    req_valid[1] = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_q", rsp_quotient, 32'hFFFF_FFFF);
      chk("stall_r", rsp_remainder, 32'd9);
      chk("stall_id", rsp_id, 0);
      chk("stall_req_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_cycle_req_ready", req_ready, 0);
    @(negedge clk);
    chk("after_hs_grant", req_ready, 32'd2);
    issue(1, 32'd50, 32'd5);
    wait_rsp(100, lat, ok);
    if (ok) chk_rsp("after_stall", 1, 32'd10, 32'd0, 1'b0);
    @(negedge clk);

    // Reset in the middle of a WAIT: everything clears, job is dropped
    force_lo = 1'b1;
    issue(0, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    req_valid[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    req_valid = '0;
    force_lo = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_reset_no_rsp", rsp_valid, 0);
    end

    // Same job twice after reset
    issue(0, 32'd100, 32'd7);
    chk("rep1_flush_dd", div_dividend, 32'hFFFF_FF9B);
    wait_rsp(100, lat, ok);
    if (ok) chk_rsp("rep1", 0, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    issue(0, 32'd100, 32'd7);
`ifdef ALU_DIV_SCHED_CACHE_EN
    chk("rep2_div_dd_hold", div_dividend, 32'd100);
    wait_rsp(100, lat, ok);
    if (ok) begin
      chk("rep2_hit_latency", lat, 1);
      chk_rsp("rep2", 0, 32'd14, 32'd2, 1'b0);
    end
`else
    chk("rep2_flush_dd", div_dividend, 32'hFFFF_FF9B);
    wait_rsp(100, lat, ok);
    if (ok) begin
      chk_ge("rep2_latency", lat, MIN_WAIT + 3);
      chk_rsp("rep2", 0, 32'd14, 32'd2, 1'b0);
    end
`endif
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
